period_gen: RTL and testbench
=============================

PERIOD_GEN -- requirements
Module: period_gen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, the input clock frequency; the tick divisor TICK_DIV = CLK_FREQ_HZ/1000 clocks per ms.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic rises on clk.
REQ-003 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a level sampled each clk; it is accepted only in IDLE.
REQ-005 The block SHALL have port period, input, 10, the output period in ms; it is latched on start acceptance.
REQ-006 The block SHALL have port n_cycles, input, 8, the number of periods to emit; it is latched on start acceptance.
REQ-007 The block SHALL have port so, output, 1, the generated square wave, registered.
REQ-008 The block SHALL have port ready, output, 1; it is high only in IDLE.
REQ-009 The block SHALL have port done_tick, output, 1, a one-clock pulse when a burst completes.
REQ-010 The block SHALL have port err_tick, output, 1, a one-clock pulse when a start is rejected.

Function
REQ-011 The block SHALL implement the state machine IDLE -> HIGH -> LOW -> (HIGH or DONE) -> IDLE.
REQ-012 In IDLE with start=1, the block SHALL latch P=period and N=n_cycles, clear the prescaler and ms counter, and enter HIGH.
REQ-013 The block SHALL raise so on the clock following start acceptance.
REQ-014 The block SHALL use a high half of H = P - (P>>1) ms and a low half of L = P>>1 ms. For odd P the extra ms goes to the high half.
REQ-015 The high phase SHALL last exactly H*TICK_DIV clocks and the low phase exactly L*TICK_DIV clocks. One full period SHALL therefore be P*TICK_DIV clocks with no gap cycles.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 and wrap. Its wrap SHALL advance the 10-bit ms counter, and the ms counter SHALL clear at every phase change.
REQ-017 At the end of each LOW phase, the block SHALL increment the 8-bit cycle counter. If the count equals N, the block SHALL enter DONE; otherwise it SHALL enter HIGH.
REQ-018 In DONE the block SHALL hold so=0, assert done_tick for exactly one clock, and enter IDLE on the next clock.
REQ-019 P<2 or N=0 SHALL reject the start: the block SHALL assert err_tick for one clock, stay in IDLE, and keep so=0. The N=0 rejection applies only when PERIOD_GEN_CONT_EN is not defined.
REQ-020 The block SHALL ignore start outside IDLE, and changes to period and n_cycles during a burst SHALL have no effect.
REQ-021 If start is held high continuously, a new burst SHALL be accepted on the first IDLE clock after DONE.
REQ-022 N=255 SHALL produce exactly 255 periods, and the cycle counter SHALL NOT wrap before the comparison.

Reset
REQ-023 Assertion of reset_n=0 SHALL asynchronously force IDLE. It SHALL also force so=0, ready=1, done_tick=0, err_tick=0, and clear all counters and latched values.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no done_tick. After release the block SHALL wait in IDLE for a new start.

Configuration
REQ-025 With macro PERIOD_GEN_CONT_EN defined, the block SHALL add input port stop (1 bit), and N=0 SHALL select continuous mode.
REQ-026 In continuous mode the block SHALL run HIGH/LOW indefinitely. It SHALL exit only at the end of the LOW phase in which stop=1 was sampled, and then go through DONE, so done_tick pulses once.
REQ-027 Without PERIOD_GEN_CONT_EN, the stop port SHALL NOT exist and N=0 SHALL be rejected per REQ-019.

Verification (CLK_FREQ_HZ=10000, TICK_DIV=10)
REQ-028 Scenario: start with P=4, N=2 -> so is high 20 clk and low 20 clk, twice; done_tick pulses 1 clk after the 80th so clock; ready returns high.
REQ-029 Scenario: start with P=5, N=1 -> so is high 30 clk then low 20 clk; exactly one done_tick.
REQ-030 Scenario: start with P=1, N=3, and separately P=10, N=0 (macro off) -> err_tick pulses once, so stays 0, ready stays 1.
REQ-031 Scenario: start with P=6, N=3; change period to 2 and pulse start mid-burst -> the waveform still uses 30/30 clk halves for 3 periods.
REQ-032 Scenario: start with P=4, N=10; assert reset_n=0 during the 2nd HIGH phase -> so=0 and ready=1 immediately, with no done_tick.
REQ-033 Scenario: macro on, start with P=2, N=0; pulse stop during the 3rd HIGH phase -> the 3rd LOW phase completes, then done_tick pulses, for 60 so clocks total.

Source files
------------

// File: rtl/period_gen.sv
// period_gen -- burst square-wave generator with a millisecond time base.
//
// A start accepted in IDLE latches a period P (in ms) and a burst length N.
// The block then emits N periods of a square wave on 'so'. Each period is a
// high half of ceil(P/2) ms followed by a low half of floor(P/2) ms. A
// one-clock done_tick marks the end of the burst, and the block returns to
// IDLE. An unusable start (P < 2, or N = 0 without continuous mode) is
// rejected with a one-clock err_tick.
//
// Parameters:
//   CLK_FREQ_HZ  input clock frequency; TICK_DIV = CLK_FREQ_HZ/1000 clocks/ms
//
// Ports:
//   clk        single clock, all logic on its rising edge
//   reset_n    asynchronous active-low reset
//   start      start request level, honoured only in IDLE
//   period     [9:0] period in ms, latched when a start is accepted
//   n_cycles   [7:0] number of periods, latched when a start is accepted
//   stop       (PERIOD_GEN_CONT_EN only) ends a continuous run
//   so         registered square-wave output
//   ready      high only while in IDLE
//   done_tick  one-clock pulse when a burst completes
//   err_tick   one-clock pulse when a start is rejected
//
// Configuration macro:
//   PERIOD_GEN_CONT_EN  adds the 'stop' input. With it, N = 0 selects a
//                       continuous run that ends at the close of the LOW
//                       phase in which stop was seen.

module period_gen #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] period,
  input  logic [7:0] n_cycles,
`ifdef PERIOD_GEN_CONT_EN
  input  logic       stop,
`endif
  output logic       so,
  output logic       ready,
  output logic       done_tick,
  output logic       err_tick
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         r_state;
  logic [9:0]     r_p;
  logic [7:0]     r_n;
  logic [PW-1:0]  r_presc;
  logic [9:0]     r_ms;
  logic [7:0]     r_cyc;
  logic           r_so;
  logic           r_ready;
  logic           r_done;
  logic           r_err;
`ifdef PERIOD_GEN_CONT_EN
  logic           r_cont;
  logic           r_stopReq;
`endif

  logic           w_tickWrap;
  logic [9:0]     w_highMs;
  logic [9:0]     w_lowMs;
  logic [9:0]     w_msNext;
  logic           w_highEnd;
  logic           w_lowEnd;
  logic [8:0]     w_cycNext;
  logic           w_lastCycle;
  logic           w_startBad;

  // The odd millisecond of an odd period goes to the high half.
  assign w_highMs = r_p - {1'b0, r_p[9:1]};
  assign w_lowMs  = {1'b0, r_p[9:1]};

  assign w_tickWrap = (r_presc == PRESC_LAST);
  assign w_msNext   = r_ms + 10'd1;

  // A phase ends on the prescaler wrap that completes its last millisecond.
  assign w_highEnd = w_tickWrap && (w_msNext == w_highMs);
  assign w_lowEnd  = w_tickWrap && (w_msNext == w_lowMs);

  // One extra bit keeps N = 255 from wrapping before the compare.
  assign w_cycNext = {1'b0, r_cyc} + 9'd1;

`ifdef PERIOD_GEN_CONT_EN
  // A stop seen in the closing LOW cycle itself also ends a continuous run.
  assign w_lastCycle = r_cont ? (r_stopReq | stop) : (w_cycNext == {1'b0, r_n});
  assign w_startBad  = (period < 10'd2);
`else
  assign w_lastCycle = (w_cycNext == {1'b0, r_n});
  assign w_startBad  = (period < 10'd2) || (n_cycles == 8'd0);
`endif

  // Single state machine; every output is a register updated alongside the
  // state, so 'so' and 'ready' change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_n       <= '0;
      r_presc   <= '0;
      r_ms      <= '0;
      r_cyc     <= '0;
      r_so      <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef PERIOD_GEN_CONT_EN
      r_cont    <= 1'b0;
      r_stopReq <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_startBad) begin
              r_err <= 1'b1;
            end else begin
              r_p     <= period;
              r_n     <= n_cycles;
              r_presc <= '0;
              r_ms    <= '0;
              r_cyc   <= '0;
              r_so    <= 1'b1;
              r_ready <= 1'b0;
              r_state <= HIGH;
`ifdef PERIOD_GEN_CONT_EN
              r_cont    <= (n_cycles == 8'd0);
              r_stopReq <= 1'b0;
`endif
            end
          end
        end

        HIGH: begin
          r_presc <= w_tickWrap ? '0 : r_presc + 1'b1;
`ifdef PERIOD_GEN_CONT_EN
          if (stop) r_stopReq <= 1'b1;
`endif
          if (w_highEnd) begin
            r_ms    <= '0;
            r_so    <= 1'b0;
            r_state <= LOW;
          end else if (w_tickWrap) begin
            r_ms <= w_msNext;
          end
        end

        LOW: begin
          r_presc <= w_tickWrap ? '0 : r_presc + 1'b1;
`ifdef PERIOD_GEN_CONT_EN
          if (stop) r_stopReq <= 1'b1;
`endif
          if (w_lowEnd) begin
            r_ms  <= '0;
            r_cyc <= w_cycNext[7:0];
            if (w_lastCycle) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_so    <= 1'b1;
              r_state <= HIGH;
            end
          end else if (w_tickWrap) begin
            r_ms <= w_msNext;
          end
        end

        DONE: begin
          r_so    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
`ifdef PERIOD_GEN_CONT_EN
          r_stopReq <= 1'b0;
`endif
        end

        default: begin
          r_so    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign so        = r_so;
  assign ready     = r_ready;
  assign done_tick = r_done;
  assign err_tick  = r_err;

endmodule

// File: tb/tb_period_gen.sv
// tb_period_gen -- self-checking bench for period_gen at CLK_FREQ_HZ=10000
// (10 clocks per ms). Expected waveforms come from a period-level model:
// each period is ceil(P/2)*10 high clocks then floor(P/2)*10 low clocks,
// followed by one done cycle and a return to ready.

module tb_period_gen;

  localparam int TD = 10;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [9:0] period;
  logic [7:0] n_cycles;
  logic       stop;
  logic       so;
  logic       ready;
  logic       done_tick;
  logic       err_tick;

  int total = 0;
  int bad   = 0;

  period_gen #(.CLK_FREQ_HZ(10000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .period    (period),
    .n_cycles  (n_cycles),
`ifdef PERIOD_GEN_CONT_EN
    .stop      (stop),
`endif
    .so        (so),
    .ready     (ready),
    .done_tick (done_tick),
    .err_tick  (err_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare all four outputs against the expected values.
  task automatic checkOutput(input string tag, input logic eSo, input logic eReady,
                             input logic eDone, input logic eErr);
    total++;
    assert (so === eSo) else begin
      bad++;
      $error("[TB] FAIL %s.so observed=%b expected=%b t=%0t", tag, so, eSo, $time);
    end
    total++;
    assert (ready === eReady) else begin
      bad++;
      $error("[TB] FAIL %s.ready observed=%b expected=%b t=%0t", tag, ready, eReady, $time);
    end
    total++;
    assert (done_tick === eDone) else begin
      bad++;
      $error("[TB] FAIL %s.done observed=%b expected=%b t=%0t", tag, done_tick, eDone, $time);
    end
    total++;
    assert (err_tick === eErr) else begin
      bad++;
      $error("[TB] FAIL %s.err observed=%b expected=%b t=%0t", tag, err_tick, eErr, $time);
    end
  endtask

  // Called at the first negedge after acceptance; checks n periods and the
  // done cycle. mode 1 scrambles inputs each cycle; mode 2 rewrites the
  // period to 2 and pulses start once, partway through the second period.
  task automatic checkBurst(input string tag, input int p, input int n, input int mode);
    int hiClk;
    int perClk;
    hiClk  = ((p + 1) / 2) * TD;
    perClk = p * TD;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < perClk; c++) begin
        checkOutput(tag, (c < hiClk), 1'b0, 1'b0, 1'b0);
        if (mode == 1) begin
          start    = 1'($urandom_range(0, 1));
          period   = 10'($urandom);
          n_cycles = 8'($urandom);
        end else if (mode == 2 && k == 1 && c == 5) begin
          period = 10'd2;
          start  = 1'b1;
        end else if (mode == 2 && k == 1 && c == 6) begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    checkOutput({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Full burst from IDLE: issue start, check the burst, check return to ready.
  task automatic applyStimulus(input string tag, input int p, input int n, input int mode);
    period   = 10'(p);
    n_cycles = 8'(n);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkBurst(tag, p, n, mode);
    start = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle"}, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Single-cycle start that must be rejected.
  task automatic applyReject(input string tag, input int p, input int n);
    period   = 10'(p);
    n_cycles = 8'(n);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_err"}, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_after"}, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    period   = '0;
    n_cycles = '0;
    stop     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset", 1'b0, 1'b1, 1'b0, 1'b0);

    // Even and odd periods.
    applyStimulus("p4n2", 4, 2, 0);
    applyStimulus("p5n1", 5, 1, 0);

    // Rejections.
    applyReject("p1n3", 1, 3);
    applyReject("p0n1", 0, 1);
`ifndef PERIOD_GEN_CONT_EN
    applyReject("p10n0", 10, 0);
`endif

    // Mid-burst period change and start pulse are ignored.
    applyStimulus("p6n3", 6, 3, 2);

    // Randomized bursts with scrambled inputs during the burst.
    for (int i = 0; i < 6; i++) begin
      int rp;
      int rn;
      rp = $urandom_range(2, 12);
      rn = $urandom_range(1, 3);
      applyStimulus("rand", rp, rn, 1);
    end

    // Start held high: re-accepted on the first IDLE clock after DONE.
    period   = 10'd3;
    n_cycles = 8'd1;
    start    = 1'b1;
    @(negedge clk);
    checkBurst("hold1", 3, 1, 0);
    @(negedge clk);
    checkOutput("hold_gap", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checkBurst("hold2", 3, 1, 0);
    @(negedge clk);
    checkOutput("hold_idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // Largest burst length.
    applyStimulus("p2n255", 2, 255, 0);

    // Reset during the second HIGH phase aborts with no done_tick.
    period   = 10'd4;
    n_cycles = 8'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      checkOutput("abort_run", ((c % 40) < 20), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1 checkOutput("abort_now", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checkOutput("abort_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    end

`ifdef PERIOD_GEN_CONT_EN
    // Continuous run: stop during the 3rd HIGH ends after the 3rd LOW.
    period   = 10'd2;
    n_cycles = 8'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2 * TD; c++) begin
        checkOutput("cont", (c < TD), 1'b0, 1'b0, 1'b0);
        stop = (k == 2 && c == 3);
        @(negedge clk);
      end
    end
    stop = 1'b0;
    checkOutput("cont_done", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("cont_idle", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
